// File: rtl/servo_pkg.sv
// Shared constants and types for the 50 Hz hobby-servo PWM generator.
package servo_pkg;

    localparam int SERVO_PERIOD_TICKS = 800;
    localparam int SERVO_MIN_TICKS    = 40;
    localparam int SERVO_MAX_TICKS    = 80;
    localparam int SERVO_CENTER_POS   = 20;
    localparam int SERVO_POS_W        = 8;

    typedef enum logic {IDLE, RUN} servo_state_t;
    typedef logic [SERVO_POS_W-1:0] servo_pos_t;

endpackage

// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: 800-tick frames with a 40..80 tick high pulse.
// Position commands land in a one-entry pending register and are applied only at frame starts.
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int PERIOD_TICKS = SERVO_PERIOD_TICKS,
    parameter int MIN_TICKS    = SERVO_MIN_TICKS,
    parameter int MAX_TICKS    = SERVO_MAX_TICKS,
    parameter int RESET_POS    = SERVO_CENTER_POS,
    parameter int POS_W        = SERVO_POS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             enable,
    input  logic [POS_W-1:0] pos_data,
    input  logic             pos_valid,
    output logic             pos_ready,
    output logic             pwm_out,
    output logic             period_start,
    output logic             pos_clamped
);

    localparam int CNT_W   = $clog2(PERIOD_TICKS);
    localparam int HT_W    = (CNT_W + 1 > POS_W + 1) ? CNT_W + 1 : POS_W + 1;
    localparam int LAST_I  = PERIOD_TICKS - 1;
    localparam int RANGE_I = MAX_TICKS - MIN_TICKS;

    localparam logic [CNT_W-1:0] LAST_CNT  = LAST_I[CNT_W-1:0];
    localparam logic [HT_W-1:0]  MIN_HT    = MIN_TICKS[HT_W-1:0];
    localparam logic [POS_W-1:0] RANGE_POS = RANGE_I[POS_W-1:0];
    localparam logic [POS_W-1:0] RST_POS   = RESET_POS[POS_W-1:0];

    if (MAX_TICKS >= PERIOD_TICKS) begin : g_bad_max
        $error("servo_pwm_gen: MAX_TICKS must be below PERIOD_TICKS");
    end

    servo_state_t     state_q, state_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [POS_W-1:0] active_pos_q, active_pos_d;
    logic [POS_W-1:0] pending_q, pending_d;
    logic             pending_full_q, pending_full_d;
    logic             pwm_q, pwm_d;
    logic             period_start_q, period_start_d;
    logic             clamped_q, clamped_d;

    logic             accept;
    logic             frame_start;
    logic [CNT_W-1:0] cnt_next;
    logic [HT_W-1:0]  high_ticks;

    assign accept     = pos_valid && !pending_full_q;
    assign cnt_next   = tick_cnt_q + 1'b1;
    assign high_ticks = MIN_HT + HT_W'(active_pos_q);

    always_comb begin
        state_d        = state_q;
        tick_cnt_d     = tick_cnt_q;
        active_pos_d   = active_pos_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        pwm_d          = pwm_q;
        period_start_d = 1'b0;
        clamped_d      = clamped_q;
        frame_start    = 1'b0;

        case (state_q)
            IDLE: begin
                pwm_d      = 1'b0;
                tick_cnt_d = '0;
                if (tick && enable) begin
                    frame_start = 1'b1;
                end
            end
            RUN: begin
                if (tick) begin
                    if (tick_cnt_q == LAST_CNT) begin
                        if (enable) begin
                            frame_start = 1'b1;
                        end else begin
                            state_d    = IDLE;
                            pwm_d      = 1'b0;
                            tick_cnt_d = '0;
                        end
                    end else begin
                        tick_cnt_d = cnt_next;
                        pwm_d      = HT_W'(cnt_next) < high_ticks;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The pending slot can only be refilled while empty, so draining and accepting never collide.
        if (frame_start) begin
            state_d        = RUN;
            tick_cnt_d     = '0;
            pwm_d          = 1'b1;
            period_start_d = 1'b1;
            if (pending_full_q) begin
                active_pos_d   = pending_q;
                pending_full_d = 1'b0;
            end
        end

        if (accept) begin
            pending_full_d = 1'b1;
            if (pos_data > RANGE_POS) begin
                pending_d = RANGE_POS;
                clamped_d = 1'b1;
            end else begin
                pending_d = pos_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            tick_cnt_q     <= '0;
            active_pos_q   <= RST_POS;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            pwm_q          <= 1'b0;
            period_start_q <= 1'b0;
            clamped_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            tick_cnt_q     <= tick_cnt_d;
            active_pos_q   <= active_pos_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
            clamped_q      <= clamped_d;
        end
    end

    assign pos_ready    = !pending_full_q;
    assign pwm_out      = pwm_q;
    assign period_start = period_start_q;
    assign pos_clamped  = clamped_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen: tick every 4 clk, pulse widths measured in clk cycles.
module tb_servo_pwm_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       enable;
    logic [7:0] pos_data;
    logic       pos_valid;
    logic       pos_ready;
    logic       pwm_out;
    logic       period_start;
    logic       pos_clamped;

    int checks   = 0;
    int failures = 0;

    int hi_run         = 0;
    int last_pulse     = 0;
    int pulse_cnt      = 0;
    int since_start    = 0;
    int last_frame_len = 0;
    int start_cnt      = 0;

    servo_pwm_gen dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .enable       (enable),
        .pos_data     (pos_data),
        .pos_valid    (pos_valid),
        .pos_ready    (pos_ready),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .pos_clamped  (pos_clamped)
    );

    always #5 clk = ~clk;

    initial begin
        int tcnt;
        tcnt = 0;
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tick = (tcnt == 3);
            tcnt = (tcnt + 1) % 4;
        end
    end

    // Pulse widths and frame lengths in clk cycles; one tick is exactly 4 clk.
    always @(negedge clk) begin
        if (pwm_out) begin
            hi_run++;
        end else if (hi_run != 0) begin
            last_pulse = hi_run;
            pulse_cnt++;
            hi_run = 0;
        end
        since_start++;
        if (period_start) begin
            last_frame_len = since_start;
            since_start = 0;
            start_cnt++;
        end
    end

    task automatic check_output(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input string tag);
        int base;
        int n;
        base = start_cnt;
        n = 0;
        while (start_cnt == base && n < 5000) begin
            step(1);
            n++;
        end
        check_output({tag, "_start_seen"}, int'(start_cnt != base), 1);
    endtask

    task automatic wait_pulse(input string tag, input int exp_ticks);
        int base;
        int n;
        base = pulse_cnt;
        n = 0;
        while (pulse_cnt == base && n < 5000) begin
            step(1);
            n++;
        end
        check_output({tag, "_pulse_seen"}, int'(pulse_cnt != base), 1);
        check_output({tag, "_high_clk"}, last_pulse, exp_ticks * 4);
    endtask

    task automatic apply_stimulus(input string tag, input int value, output int waited);
        logic rdy;
        pos_data  = value[7:0];
        pos_valid = 1'b1;
        waited = 0;
        rdy = pos_ready;
        while (waited < 5000) begin
            rdy = pos_ready;
            step(1);
            if (rdy) break;
            waited++;
        end
        pos_valid = 1'b0;
        check_output({tag, "_accepted"}, int'(rdy), 1);
    endtask

    initial begin
        int w;
        int sc;
        int pc;
        rst       = 1'b1;
        enable    = 1'b0;
        pos_data  = '0;
        pos_valid = 1'b0;
        step(5);

        check_output("rst_pwm", int'(pwm_out), 0);
        check_output("rst_period_start", int'(period_start), 0);
        check_output("rst_pos_ready", int'(pos_ready), 1);
        check_output("rst_pos_clamped", int'(pos_clamped), 0);

        rst = 1'b0;
        enable = 1'b1;
        wait_start("f1");
        wait_pulse("f1_centre", 60);
        wait_start("f2");
        check_output("frame_len_clk", last_frame_len, 3200);

        $display("[TB] write pos=0 mid-pulse");
        step(40);
        apply_stimulus("w0", 0, w);
        check_output("ready_after_accept", int'(pos_ready), 0);
        wait_pulse("f2_unchanged", 60);
        check_output("ready_until_boundary", int'(pos_ready), 0);
        wait_start("f3");
        check_output("ready_after_boundary", int'(pos_ready), 1);
        wait_pulse("f3_pos0", 40);

        $display("[TB] write pos=40 then pos=10 in one frame");
        apply_stimulus("w40", 40, w);
        apply_stimulus("w10", 10, w);
        check_output("second_write_stalled", int'(w > 100), 1);
        wait_pulse("f4_pos40", 80);
        wait_start("f5");
        wait_pulse("f5_pos10", 50);
        check_output("clamped_still_0", int'(pos_clamped), 0);

        $display("[TB] write pos=200 (clamped)");
        apply_stimulus("w200", 200, w);
        check_output("clamped_set", int'(pos_clamped), 1);
        wait_start("f6");
        wait_pulse("f6_clamped", 80);
        check_output("clamped_sticky", int'(pos_clamped), 1);

        $display("[TB] back to centre, then drop enable at tick 30");
        apply_stimulus("w20", 20, w);
        wait_start("f7");
        step(119);
        enable = 1'b0;
        sc = start_cnt;
        wait_pulse("f7_not_truncated", 60);
        pc = pulse_cnt;
        step(4000);
        check_output("parked_no_start", start_cnt, sc);
        check_output("parked_no_pulse", pulse_cnt, pc);
        check_output("parked_pwm_low", int'(pwm_out), 0);
        enable = 1'b1;
        wait_start("reenable");
        wait_pulse("reenable_centre", 60);

        $display("[TB] reset mid-pulse with pending value");
        wait_start("f8");
        apply_stimulus("w5", 5, w);
        step(76);
        check_output("pre_rst_pwm_high", int'(pwm_out), 1);
        rst = 1'b1;
        step(1);
        check_output("mid_rst_pwm", int'(pwm_out), 0);
        check_output("mid_rst_ready", int'(pos_ready), 1);
        check_output("mid_rst_clamped", int'(pos_clamped), 0);
        check_output("mid_rst_period_start", int'(period_start), 0);
        rst = 1'b0;
        wait_start("post_rst");
        wait_pulse("post_rst_centre", 60);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
